mem_port_arbiter: RTL

- Shares the core's single-port unified memory between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the core pipeline and the memory array (the array is loaded from the test hex image).
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to its owner.
- Guarantees fetch forward progress under sustained load/store traffic.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 38 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned WORD_LSB             = 2;
  localparam int unsigned WORD_W               = 16;
  localparam int unsigned DATA_W               = 32;
  localparam int unsigned STRB_W               = 4;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_I      = 2'd1,
    OWN_D_LOAD = 2'd2
  } owner_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts cycles fetch waits behind load/store grants; flags when fetch must win.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter  int unsigned LIMIT = DEFAULT_STARVE_LIMIT,
  localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (!i_req || i_gnt) begin
      cnt_d = '0;
    end else if (d_gnt && (cnt != CNT_W'(LIMIT))) begin
      cnt_d = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

  assign force_i_c = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one single-port memory and
// routes the 1-cycle read response back to the requester that owns it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_WORDS    = 65536,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  output grant_e            last_grant
);

  logic [ADDR_W-1:0] i_word;
  logic [ADDR_W-1:0] d_word;
  logic              i_oor;
  logic              d_oor;
  logic              force_i_c;
  owner_e            owner_q;
  owner_e            owner_d;
  logic              err_q;
  logic              err_d;

  // Byte address -> word index; the low two bits are dropped here.
  assign i_word = i_addr >> WORD_LSB;
  assign d_word = d_addr >> WORD_LSB;
  assign i_oor  = (i_word[ADDR_W-1:WORD_W] != '0) || (32'(i_word[WORD_W-1:0]) >= MEM_WORDS);
  assign d_oor  = (d_word[ADDR_W-1:WORD_W] != '0) || (32'(d_word[WORD_W-1:0]) >= MEM_WORDS);

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_gnt     (i_gnt),
    .d_gnt     (d_gnt),
    .force_i_c (force_i_c)
  );

  // Grant select, memory drive and next response owner.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    owner_d   = OWN_NONE;
    err_d     = 1'b0;
    if (!rst) begin
      i_gnt = i_req && (!d_req || force_i_c);
      d_gnt = d_req && !i_gnt;
    end
    if (i_gnt) begin
      mem_en   = !i_oor;
      mem_addr = i_word[WORD_W-1:0];
      owner_d  = OWN_I;
      err_d    = i_oor;
    end else if (d_gnt) begin
      mem_en    = !d_oor;
      mem_we    = d_we && !d_oor;
      mem_addr  = d_word[WORD_W-1:0];
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
      owner_d   = d_we ? OWN_NONE : OWN_D_LOAD;
      err_d     = !d_we && d_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      err_q      <= 1'b0;
      last_grant <= GNT_I;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      if (i_gnt) begin
        last_grant <= GNT_I;
      end else if (d_gnt) begin
        last_grant <= GNT_D;
      end
    end
  end

  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D_LOAD);
  assign i_err    = i_rvalid && err_q;
  assign i_rdata  = (i_rvalid && !err_q) ? mem_rdata : '0;
  assign d_rdata  = (d_rvalid && !err_q) ? mem_rdata : '0;
  // Store range errors are reported in the grant cycle, load errors with the response.
  assign d_err    = (d_rvalid && err_q) || (d_gnt && d_we && d_oor);

endmodule
